md_unit: RTL and testbench
==========================

# md_unit

Iterative multiply/divide unit for the small MIPS core, with the architectural HI/LO registers. Operands arrive straight from the register file read ports (rs → o_rdata1, rt → o_rdata2) in the execute stage. Results are held in HI/LO for later MFHI/MFLO, whose data returns to the register file write port through writeback. The pipeline stalls on `o_busy`.

## Interface
Parameters:
- none

Ports:
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: launch the operation in `i_op`.
- `i_op` in 2: operation select.
  - `00` MULT
  - `01` MULTU
  - `10` DIV
  - `11` DIVU
- `i_rs` in 32: operand A (multiplicand / dividend).
- `i_rt` in 32: operand B (multiplier / divisor).
- `i_hi_we` in 1: MTHI write strobe.
- `i_lo_we` in 1: MTLO write strobe.
- `i_wdata` in 32: MTHI/MTLO data.
- `o_busy` in/out: out 1; operation in flight, stall request.
- `o_done` out 1: one-cycle pulse when HI/LO take a new result.
- `o_hi` out 32: HI register.
- `o_lo` out 32: LO register.

## Operation
- States:
  - IDLE: accepts start and MTHI/MTLO.
  - CALC: 32 iterations, 5-bit counter 0..31.
  - FIX: sign correction, HI/LO load.
- IDLE → CALC on `i_start`. Operands are latched at that edge, then converted to magnitudes if the op is signed.
- CALC → FIX when the counter reaches 31. FIX → IDLE unconditionally.
- Multiply uses shift-add over a 64-bit product.
  - HI = product[63:32], LO = product[31:0].
  - Signed result is negated when the operand signs differ.
- Divide uses restoring division.
  - LO = quotient, HI = remainder.
  - Signed: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - 0x8000_0000 / 0xFFFF_FFFF (DIV) gives LO = 0x8000_0000, HI = 0.
- Divide by zero (DIV or DIVU) still takes the full latency.
  - HI = dividend unchanged.
  - LO = 0xFFFF_FFFF.
- MTHI/MTLO in IDLE: `o_hi`/`o_lo` take `i_wdata` at the next edge. Both strobes together write both registers.
- `i_start` and `i_hi_we`/`i_lo_we` in the same IDLE cycle: the start wins and the writes are dropped.
- `i_start`, `i_hi_we` and `i_lo_we` are ignored while busy (CALC or FIX).

## Timing
- Reset (`i_rst_n` = 0 at an edge) gives state IDLE, `o_busy` = 0, `o_done` = 0, `o_hi` = 0, `o_lo` = 0, counter 0.
- Reset mid-operation aborts with no `o_done` pulse, and HI/LO are cleared.
- Start sampled at edge N:
  - `o_busy` is high after edge N through edge N+32.
  - HI/LO update at edge N+33.
  - `o_done` is high for exactly the cycle after edge N+33; `o_busy` is low in that cycle.
- Latency is 33 cycles from start edge to result.
- A new `i_start` is accepted in the `o_done` cycle (back-to-back operation).
- `o_busy` is registered and depends only on state.
- `o_hi` and `o_lo` are registered and stable except at a result or MT write edge.

## Configuration
- `MD_FAST_MUL_EN` defined:
  - MULT/MULTU skip CALC and go IDLE → FIX, using a single-cycle 32×32 `*` product (signed or unsigned per op).
  - Start at edge N gives result at edge N+1 and `o_done` after edge N+1, with `o_busy` high for one cycle.
  - Division is unchanged (33 cycles).
- Undefined: all operations use the 33-cycle iterative path.

## Structure
- Package `md_pkg`:
  - op encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`)
  - state enum (`MD_IDLE`, `MD_CALC`, `MD_FIX`)
  - `MD_ITER` = 32
  - `MD_DIV0_LO` = 32'hFFFF_FFFF
- Sub-module `md_step`: combinational single iteration that takes the accumulator/remainder, operand and op class, and returns the next accumulator plus the quotient bit. It is instantiated once in `md_unit`.
- Sign pre/post-processing stays in `md_unit`.

## Test plan
- MULTU 0xFFFF_FFFF × 0x0000_0002, start at edge N → at edge N+33, HI = 0x0000_0001, LO = 0xFFFF_FFFE; `o_done` is a single pulse; `o_busy` is high for 33 cycles.
- MULT 0xFFFF_FFFD (−3) × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB; with `MD_FAST_MUL_EN` the same values appear after 1 cycle.
- DIV 0xFFFF_FFF9 (−7) / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0.
- DIVU 0x64 / 0 → HI = 0x0000_0064, LO = 0xFFFF_FFFF after 33 cycles.
- MTLO 0xDEAD_BEEF in IDLE → `o_lo` = 0xDEAD_BEEF next cycle.
- Second `i_start` and MTHI 0x1234 issued at cycle 5 of a DIVU → both ignored; the DIVU result is unaffected.
- `i_rst_n` low at cycle 10 of a MULT → next cycle `o_busy` = 0, `o_hi` = `o_lo` = 0, and no `o_done` ever follows.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings, state enum and helpers for the md_unit multiply/divide block.
// The optional single-cycle multiplier is enabled in md_unit by defining MD_FAST_MUL_EN.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    localparam int          MD_ITER    = 32;
    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

    // Magnitude of a value that is two's complement only when en is set
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_step.sv
// One shift-add multiply or restoring-divide iteration over the packed {hi,lo} accumulator.
module md_step
    import md_pkg::*;
(
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    input  logic        is_div,
    output logic [63:0] acc_out,
    output logic        q_bit
);

    logic [32:0] sum_s;
    logic [32:0] shl_s;
    logic [31:0] diff_s;

    // Multiply shifts right with carry; divide shifts left and leaves bit 0 for the quotient bit
    always_comb begin
        sum_s   = {1'b0, acc_in[63:32]} + {1'b0, (acc_in[0] ? operand : 32'd0)};
        shl_s   = acc_in[63:31];
        diff_s  = shl_s[31:0] - operand;
        q_bit   = 1'b0;
        acc_out = {sum_s, acc_in[31:1]};
        if (is_div) begin
            q_bit   = (shl_s >= {1'b0, operand});
            acc_out = {(q_bit ? diff_s : shl_s[31:0]), acc_in[30:0], 1'b0};
        end else begin
            q_bit   = 1'b0;
            acc_out = {sum_s, acc_in[31:1]};
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MD_FAST_MUL_EN to resolve multiplies in a single cycle via a direct product.
module md_unit
    import md_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_hi_we,
    input  logic        i_lo_we,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [4:0] LAST_CNT = 5'(MD_ITER - 1);

    md_state_e   state_r, state_s;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;
    logic [31:0] b_r;
    logic [31:0] a_r;
    logic        div_r, div0_r, neg_q_r, neg_rem_r;
    logic [31:0] hi_r, lo_r;
    logic        busy_r, busy_s, done_r, done_s;
    logic        signed_s;
    logic [63:0] step_acc_s;
    logic        q_bit_s;

    assign signed_s = ~i_op[0];

`ifdef MD_FAST_MUL_EN
    logic [63:0] fast_prod_s;
    // Sign-extending per op lets one truncated 64-bit product serve both MULT and MULTU
    assign fast_prod_s = {{32{signed_s & i_rs[31]}}, i_rs} * {{32{signed_s & i_rt[31]}}, i_rt};
`endif

    md_step u_step (
        .acc_in  (acc_r),
        .operand (b_r),
        .is_div  (div_r),
        .acc_out (step_acc_s),
        .q_bit   (q_bit_s)
    );

    // State register plus registered busy/done flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r <= MD_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (i_start) begin
`ifdef MD_FAST_MUL_EN
                    state_s = i_op[1] ? MD_CALC : MD_FIX;
`else
                    state_s = MD_CALC;
`endif
                end else begin
                    state_s = MD_IDLE;
                end
            end
            MD_CALC: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = MD_FIX;
                end else begin
                    state_s = MD_CALC;
                end
            end
            MD_FIX:  state_s = MD_IDLE;
            default: state_s = MD_IDLE;
        endcase
    end

    // Output decode; busy follows the upcoming state so the flag itself is a flop
    always_comb begin
        busy_s = (state_s != MD_IDLE);
        done_s = (state_r == MD_FIX);
    end

    // Operand capture, iteration, sign fix-up and HI/LO writes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_r     <= 5'd0;
            acc_r     <= 64'd0;
            b_r       <= 32'd0;
            a_r       <= 32'd0;
            div_r     <= 1'b0;
            div0_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (i_start) begin
                        cnt_r     <= 5'd0;
                        acc_r     <= {32'd0, md_abs(i_rs, signed_s)};
                        b_r       <= md_abs(i_rt, signed_s);
                        a_r       <= i_rs;
                        div_r     <= i_op[1];
                        div0_r    <= i_op[1] & (i_rt == 32'd0);
                        neg_q_r   <= signed_s & (i_rs[31] ^ i_rt[31]);
                        neg_rem_r <= signed_s & i_rs[31];
`ifdef MD_FAST_MUL_EN
                        if (!i_op[1]) begin
                            acc_r   <= fast_prod_s;
                            neg_q_r <= 1'b0;
                        end else begin
                            acc_r   <= {32'd0, md_abs(i_rs, signed_s)};
                        end
`endif
                    end else begin
                        if (i_hi_we) begin
                            hi_r <= i_wdata;
                        end else begin
                            hi_r <= hi_r;
                        end
                        if (i_lo_we) begin
                            lo_r <= i_wdata;
                        end else begin
                            lo_r <= lo_r;
                        end
                    end
                end
                MD_CALC: begin
                    cnt_r <= cnt_r + 5'd1;
                    acc_r <= {step_acc_s[63:1], step_acc_s[0] | q_bit_s};
                end
                MD_FIX: begin
                    if (!div_r) begin
                        {hi_r, lo_r} <= neg_q_r ? (64'd0 - acc_r) : acc_r;
                    end else if (div0_r) begin
                        hi_r <= a_r;
                        lo_r <= MD_DIV0_LO;
                    end else begin
                        lo_r <= neg_q_r   ? (32'd0 - acc_r[31:0])  : acc_r[31:0];
                        hi_r <= neg_rem_r ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
                    end
                end
                default: begin
                    cnt_r <= 5'd0;
                end
            endcase
        end
    end

    assign o_busy = busy_r;
    assign o_done = done_r;
    assign o_hi   = hi_r;
    assign o_lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, results, MT writes, busy masking and reset abort.
module tb_md_unit;

`ifdef MD_FAST_MUL_EN
    localparam int MUL_LAT = 1;
    localparam logic [1:0] ABORT_OP = 2'b10;
`else
    localparam int MUL_LAT = 33;
    localparam logic [1:0] ABORT_OP = 2'b00;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_rs = 32'd0;
    logic [31:0] i_rt = 32'd0;
    logic        i_hi_we = 1'b0;
    logic        i_lo_we = 1'b0;
    logic [31:0] i_wdata = 32'd0;
    logic        o_busy, o_done;
    logic [31:0] o_hi, o_lo;

    int n_vec = 0;
    int n_err = 0;

    md_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
        .i_rs(i_rs), .i_rt(i_rt), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
        .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 i_clk = ~i_clk;

    // Launch an op and wait (bounded) for o_done; lat counts edges after the start edge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int busy_n);
        @(negedge i_clk);
        i_op = op; i_rs = a; i_rt = b; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        lat = 0;
        busy_n = o_busy ? 1 : 0;
        while (!o_done && lat < 100) begin
            @(posedge i_clk); #1;
            lat++;
            if (o_busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", o_done); end
        n_vec++; if (o_hi !== 32'd0) begin n_err++; $display("FAIL reset_hi got %h exp 0", o_hi); end
        n_vec++; if (o_lo !== 32'd0) begin n_err++; $display("FAIL reset_lo got %h exp 0", o_lo); end
        i_rst_n = 1'b1;
    endtask

    task automatic test_multu();
        int lat, bn;
        run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, lat, bn);
        n_vec++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL multu_lat got %0d exp %0d", lat, MUL_LAT); end
        n_vec++; if (bn !== MUL_LAT) begin n_err++; $display("FAIL multu_busy got %0d exp %0d", bn, MUL_LAT); end
        n_vec++; if (o_hi !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hi got %h exp 00000001", o_hi); end
        n_vec++; if (o_lo !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_lo got %h exp fffffffe", o_lo); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL multu_busy_done got %b exp 0", o_busy); end
        @(posedge i_clk); #1;
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b exp 0", o_done); end
    endtask

    task automatic test_mult();
        int lat, bn;
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, bn);
        n_vec++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL mult_lat got %0d exp %0d", lat, MUL_LAT); end
        n_vec++; if (o_hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi got %h exp ffffffff", o_hi); end
        n_vec++; if (o_lo !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo got %h exp ffffffeb", o_lo); end
        run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, bn);
        n_vec++; if (o_hi !== 32'd0) begin n_err++; $display("FAIL mult_negneg_hi got %h exp 0", o_hi); end
        n_vec++; if (o_lo !== 32'd6) begin n_err++; $display("FAIL mult_negneg_lo got %h exp 6", o_lo); end
    endtask

    task automatic test_div();
        int lat, bn;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, bn);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL div_lat got %0d exp 33", lat); end
        n_vec++; if (bn !== 33) begin n_err++; $display("FAIL div_busy got %0d exp 33", bn); end
        n_vec++; if (o_lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo got %h exp fffffffd", o_lo); end
        n_vec++; if (o_hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi got %h exp ffffffff", o_hi); end
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, lat, bn);
        n_vec++; if (o_lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_posneg_lo got %h exp fffffffd", o_lo); end
        n_vec++; if (o_hi !== 32'h0000_0001) begin n_err++; $display("FAIL div_posneg_hi got %h exp 00000001", o_hi); end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
        n_vec++; if (o_lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo got %h exp 80000000", o_lo); end
        n_vec++; if (o_hi !== 32'd0) begin n_err++; $display("FAIL div_ovf_hi got %h exp 0", o_hi); end
        run_op(2'b11, 32'd100, 32'd7, lat, bn);
        n_vec++; if (o_lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got %h exp e", o_lo); end
        n_vec++; if (o_hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got %h exp 2", o_hi); end
    endtask

    task automatic test_div_zero();
        int lat, bn;
        run_op(2'b11, 32'h0000_0064, 32'd0, lat, bn);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL divu0_lat got %0d exp 33", lat); end
        n_vec++; if (o_hi !== 32'h0000_0064) begin n_err++; $display("FAIL divu0_hi got %h exp 00000064", o_hi); end
        n_vec++; if (o_lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divu0_lo got %h exp ffffffff", o_lo); end
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, lat, bn);
        n_vec++; if (o_hi !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL div0_hi got %h exp fffffffb", o_hi); end
        n_vec++; if (o_lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div0_lo got %h exp ffffffff", o_lo); end
    endtask

    task automatic test_mt();
        @(negedge i_clk); i_lo_we = 1'b1; i_wdata = 32'hDEAD_BEEF;
        @(posedge i_clk); #1; i_lo_we = 1'b0;
        n_vec++; if (o_lo !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mtlo got %h exp deadbeef", o_lo); end
        @(negedge i_clk); i_hi_we = 1'b1; i_wdata = 32'h0000_0055;
        @(posedge i_clk); #1; i_hi_we = 1'b0;
        n_vec++; if (o_hi !== 32'h0000_0055) begin n_err++; $display("FAIL mthi got %h exp 00000055", o_hi); end
        n_vec++; if (o_lo !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mthi_lo_kept got %h exp deadbeef", o_lo); end
        @(negedge i_clk); i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h1111_2222;
        @(posedge i_clk); #1; i_hi_we = 1'b0; i_lo_we = 1'b0;
        n_vec++; if (o_hi !== 32'h1111_2222) begin n_err++; $display("FAIL mt_both_hi got %h exp 11112222", o_hi); end
        n_vec++; if (o_lo !== 32'h1111_2222) begin n_err++; $display("FAIL mt_both_lo got %h exp 11112222", o_lo); end
    endtask

    task automatic test_start_wins();
        int lat, bn;
        @(negedge i_clk);
        i_op = 2'b11; i_rs = 32'd9; i_rt = 32'd4; i_start = 1'b1; i_hi_we = 1'b1; i_wdata = 32'h7777_7777;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_hi_we = 1'b0;
        n_vec++; if (o_hi !== 32'h1111_2222) begin n_err++; $display("FAIL start_wins_hi got %h exp 11112222", o_hi); end
        lat = 0;
        while (!o_done && lat < 100) begin @(posedge i_clk); #1; lat++; end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL start_wins_lat got %0d exp 33", lat); end
        n_vec++; if (o_hi !== 32'd1 || o_lo !== 32'd2) begin n_err++; $display("FAIL start_wins_res got %h_%h exp 00000001_00000002", o_hi, o_lo); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge i_clk); i_hi_we = 1'b1; i_lo_we = 1'b1; i_wdata = 32'h0BAD_0BAD;
        @(posedge i_clk); #1; i_hi_we = 1'b0; i_lo_we = 1'b0;
        @(negedge i_clk); i_op = 2'b11; i_rs = 32'd1000; i_rt = 32'd10; i_start = 1'b1;
        @(posedge i_clk); #1; i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_start = 1'b1; i_op = 2'b01; i_rs = 32'd3; i_rt = 32'd5; i_hi_we = 1'b1; i_wdata = 32'h0000_1234;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_hi_we = 1'b0;
        n_vec++; if (o_hi !== 32'h0BAD_0BAD) begin n_err++; $display("FAIL busy_mthi got %h exp 0bad0bad", o_hi); end
        lat = 5;
        while (!o_done && lat < 100) begin @(posedge i_clk); #1; lat++; end
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL busy_lat got %0d exp 33", lat); end
        n_vec++; if (o_lo !== 32'd100) begin n_err++; $display("FAIL busy_lo got %h exp 64", o_lo); end
        n_vec++; if (o_hi !== 32'd0) begin n_err++; $display("FAIL busy_hi got %h exp 0", o_hi); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        run_op(2'b11, 32'd50, 32'd8, lat, bn);
        run_op(2'b11, 32'd77, 32'd10, lat, bn);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_lat got %0d exp 33", lat); end
        n_vec++; if (o_lo !== 32'd7 || o_hi !== 32'd7) begin n_err++; $display("FAIL b2b_res got %h_%h exp 00000007_00000007", o_hi, o_lo); end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge i_clk); i_op = ABORT_OP; i_rs = 32'd12345; i_rt = 32'd678; i_start = 1'b1;
        @(posedge i_clk); #1; i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        @(negedge i_clk); i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b exp 0", o_busy); end
        n_vec++; if (o_hi !== 32'd0 || o_lo !== 32'd0) begin n_err++; $display("FAIL abort_hilo got %h_%h exp 0_0", o_hi, o_lo); end
        i_rst_n = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge i_clk); #1; if (o_done) dones++; end
        n_vec++; if (dones !== 0) begin n_err++; $display("FAIL abort_done got %0d pulses exp 0", dones); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_mt();
        test_start_wins();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
